alu_pipe: RTL

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 106 ++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: single-issue ALU with a registered result stage and a radix-2 shift-add multiplier.
module alu_pipe #(
   parameter int         WIDTH     = 32,
   parameter logic [3:0] FLAG_INIT = 4'b0000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       ops,
   input  logic             mul,
   input  logic             set_flags,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             n,
   output logic             z,
   output logic             c,
   output logic             v,
   output logic             busy
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic {IDLE, MUL} state_t;
   state_t           state, state_nx;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] mcand, mplier, acc, prod, res, x, y;
   logic [WIDTH:0]   sum;
   logic             accept, done, arith, cin, upd, msf;
   assign busy     = state == MUL;
   assign in_ready = !busy && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign done     = busy && cnt == CW'(1);
   assign prod     = acc + (mplier[0] ? mcand : '0);
   always_comb begin
      state_nx = (state == IDLE && accept && mul) ? MUL : done ? IDLE : state;
   end
   // Subtracts are folded into an adder: the subtrahend is inverted and the carry-in supplies the +1 (or stored c).
   always_comb begin
      arith = ops inside {[4'd2:4'd7], 4'd10, 4'd11};
      x     = (ops == 4'd3 || ops == 4'd7) ? b : a;
      y     = ops inside {4'd2, 4'd6, 4'd10} ? ~b : (ops == 4'd3 || ops == 4'd7) ? ~a : b;
      cin   = ops inside {[4'd5:4'd7]} ? c : ops inside {4'd2, 4'd3, 4'd10};
      sum   = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
      upd   = ops[3:2] == 2'b10 || set_flags;
      case (ops)
         4'd0, 4'd8: res = a & b;
         4'd1, 4'd9: res = a ^ b;
         4'd12:      res = a | b;
         4'd13:      res = b;
         4'd14:      res = a & ~b;
         4'd15:      res = ~b;
         default:    res = sum[WIDTH-1:0];
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s            <= '0;
         out_valid    <= 1'b0;
         {n, z, c, v} <= FLAG_INIT;
         cnt          <= '0;
         acc          <= '0;
         mcand        <= '0;
         mplier       <= '0;
         msf          <= 1'b0;
      end else if (accept && mul) begin
         mcand     <= a;
         mplier    <= b;
         acc       <= '0;
         cnt       <= CW'(WIDTH);
         msf       <= set_flags;
         out_valid <= 1'b0;
      end else if (accept) begin
         s         <= res;
         out_valid <= 1'b1;
         if (upd) begin
            n <= res[WIDTH-1];
            z <= res == '0;
            if (arith) begin
               c <= sum[WIDTH];
               v <= (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
            end
         end
      end else if (busy) begin
         acc    <= prod;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt - CW'(1);
         if (done) begin
            s         <= prod;
            out_valid <= 1'b1;
            if (msf) begin
               n <= prod[WIDTH-1];
               z <= prod == '0;
            end
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule
